// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative radix-2 multiply / restoring divide unit.
// Holds the pipeline through stall_o until results land; supports abort and MTHI/MTLO.
module hilo_muldiv #(
   parameter int WIDTH    = 32,
   parameter bit FAST_MUL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             stall_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic isNeg);
      return isNeg ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] fixSign(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] fixProduct(input logic [2*WIDTH-1:0] p, input logic neg);
      return neg ? -p : p;
   endfunction

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               busyR, doneR;
   logic [WIDTH-1:0]   hiR, loR;

   // Shared iteration register: multiply {acc, multiplier}, divide {remainder, quotient}
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   opB, rawA;
   logic               negRes, negRem, divZero, ovf;

   logic               isMul, isDiv, isSignedOp, accept, lastIter;
   logic               inSignA, inSignB;
   logic [WIDTH-1:0]   inMagA, inMagB;
   logic [2*WIDTH-1:0] fastProd;
   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] mulNext;
   logic [WIDTH:0]     divShift, divDiff;
   logic               qBit;
   logic [WIDTH-1:0]   remNext;
   logic [2*WIDTH-1:0] divNext;
   logic [WIDTH-1:0]   finHi, finLo;

   assign isMul      = (op_i == OP_MULT) || (op_i == OP_MULTU);
   assign isDiv      = (op_i == OP_DIV)  || (op_i == OP_DIVU);
   assign isSignedOp = (op_i == OP_MULT) || (op_i == OP_DIV);
   assign accept     = start_i && !flush_i && ((state == IDLE) || (state == DONE));
   assign lastIter   = (cnt == CW'(WIDTH-1));

   assign inSignA  = isSignedOp && a_i[WIDTH-1];
   assign inSignB  = isSignedOp && b_i[WIDTH-1];
   assign inMagA   = magnitude(a_i, inSignA);
   assign inMagB   = magnitude(b_i, inSignB);
   assign fastProd = fixProduct({{WIDTH{1'b0}}, inMagA} * {{WIDTH{1'b0}}, inMagB}, inSignA ^ inSignB);

   assign mulSum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});
   assign mulNext = {mulSum, prod[WIDTH-1:1]};

   assign divShift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
   assign divDiff  = divShift - {1'b0, opB};
   assign qBit     = ~divDiff[WIDTH];
   assign remNext  = qBit ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
   assign divNext  = {remNext, prod[WIDTH-2:0], qBit};

   // Sign fix-up and divide special cases applied on the final iteration
   always_comb begin
      finHi = '0;
      finLo = '0;
      if (state == MUL) begin
         {finHi, finLo} = fixProduct(mulNext, negRes);
      end else if (divZero) begin
         finHi = rawA;
         finLo = '1;
      end else if (ovf) begin
         finHi = '0;
         finLo = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         finLo = fixSign(divNext[WIDTH-1:0], negRes);
         finHi = fixSign(divNext[2*WIDTH-1:WIDTH], negRem);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         busyR <= 1'b0;
         doneR <= 1'b0;
         hiR   <= '0;
         loR   <= '0;
      end else begin
         case (state)
            MUL, DIV: begin
               if (flush_i) begin
                  state <= IDLE;
                  busyR <= 1'b0;
                  cnt   <= '0;
               end else if (lastIter) begin
                  state <= DONE;
                  busyR <= 1'b0;
                  doneR <= 1'b1;
                  cnt   <= '0;
                  hiR   <= finHi;
                  loR   <= finLo;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busyR <= 1'b0;
               doneR <= 1'b0;
               cnt   <= '0;
               if (start_i && !flush_i) begin
                  case (op_i)
                     OP_MULT, OP_MULTU: begin
                        if (FAST_MUL) begin
                           {hiR, loR} <= fastProd;
                           state      <= DONE;
                           doneR      <= 1'b1;
                        end else begin
                           state <= MUL;
                           busyR <= 1'b1;
                        end
                     end
                     OP_DIV, OP_DIVU: begin
                        state <= DIV;
                        busyR <= 1'b1;
                     end
                     OP_MTHI: hiR <= a_i;
                     OP_MTLO: loR <= a_i;
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   // Operand capture and iteration datapath; left unreset since the FSM gates its use
   always_ff @(posedge clk) begin
      if (accept && (isMul || isDiv)) begin
         prod    <= {{WIDTH{1'b0}}, inMagA};
         opB     <= inMagB;
         rawA    <= a_i;
         negRes  <= inSignA ^ inSignB;
         negRem  <= inSignA;
         divZero <= (b_i == '0);
         ovf     <= isSignedOp && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
      end else if (state == MUL) begin
         prod <= mulNext;
      end else if (state == DIV) begin
         prod <= divNext;
      end
   end

   assign stall_o = !rst && ((state == MUL) || (state == DIV) ||
                    (((state == IDLE) || (state == DONE)) && start_i &&
                     (((op_i <= OP_DIVU) && !FAST_MUL) || isDiv)));

   assign busy_o = busyR;
   assign done_o = doneR;
   assign hi_o   = hiR;
   assign lo_o   = loR;

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the pipelined MIPS core. It sits beside the EX stage and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO. It runs iterative radix-2 shift-add multiply and restoring divide, and raises a stall so the pipeline holds until results land in HI/LO. It generalises the core's plain HI/LO write path to arbitrary datapath width and adds arithmetic, abort and stall behaviour.

## Interface
- WIDTH, 32, operand and HI/LO width (≥4, even).
- FAST_MUL, 0, when 1 MULT/MULTU complete in one cycle; when 0 they iterate.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  op valid this cycle (EX stage, not flushed).
- op_i  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored.
- a_i  in  WIDTH  rs operand / dividend / MTHI-MTLO data.
- b_i  in  WIDTH  rt operand / divisor.
- flush_i  in  1  abort an in-flight mul/div.
- busy_o  out  1  iteration in progress.
- done_o  out  1  one-cycle pulse: HI/LO were just updated by mul/div.
- stall_o  out  1  combinational; hold the IF/ID/EX stages.
- hi_o, lo_o  out  WIDTH  current HI/LO register values.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_i with op 0/1 and FAST_MUL=0 -> MUL.
  - op 0/1 with FAST_MUL=1 -> DONE, with HI/LO written at that edge.
  - op 2/3 -> DIV.
  - op 4/5 writes HI/LO at that edge and stays in IDLE. No busy, no done.
- Operands latch on the accepting edge; a_i/b_i may change afterwards.
- Signed ops work on magnitudes; sign fix-up happens on completion.
  - Product is negative iff operand signs differ.
  - Quotient is negative iff signs differ.
  - Remainder takes the dividend's sign.
- MUL/DIV run an iteration counter from 0 to WIDTH-1. At the last iteration edge HI/LO are written and the FSM goes to DONE.
- Multiply result: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2·WIDTH product.
- Divide result: LO = quotient, HI = remainder.
- Divide by zero: HI = latched dividend (raw a), LO = all ones. Same latency as a normal divide.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- DONE lasts one cycle with done_o=1, then returns to IDLE. A start_i seen in DONE is accepted as if in IDLE.
- start_i while in MUL/DIV is ignored.
- stall_o = (state is MUL or DIV) OR (state is IDLE or DONE, start_i=1, and op is 0–3 with FAST_MUL=0 or op is 2–3).
- flush_i in MUL/DIV moves to IDLE at the next edge. HI/LO are unchanged, no done pulse. flush_i outranks start_i in the same cycle; the op is not accepted.
- rst at any point (including mid-op) -> IDLE, counter 0, HI=LO=0.

## Timing
- Reset values:
  - busy_o=0, done_o=0, hi_o=0, lo_o=0.
  - stall_o forced to 0 while rst=1.
- Start accepted at edge E0. busy_o is 1 during cycles E0+1 … E0+WIDTH.
- HI/LO are updated and done_o=1 in cycle E0+WIDTH+1. Total latency is WIDTH+1 cycles.
- FAST_MUL=1 multiply: HI/LO valid and done_o=1 in cycle E0+1.
- stall_o is high in the start cycle, combinationally from start_i, and through all busy cycles. It is low in the DONE cycle, so a dependent MFHI/MFLO issued then reads new values.
- MTHI/MTLO: hi_o/lo_o show new data the cycle after the edge.
- Back-to-back ops: a start in the DONE cycle begins the next op with no bubble.

## Test plan
- MULT a=0xFFFFFFFF, b=7 (WIDTH=32) -> done_o at cycle E0+33, HI=0xFFFFFFFF, LO=0xFFFFFFF9, stall_o high for 33 cycles.
- MULTU a=0xFFFFFFFF, b=7 -> HI=0x00000006, LO=0xFFFFFFF9. Repeat with FAST_MUL=1 -> same values at E0+1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=100, b=0 -> HI=0x00000064, LO=0xFFFFFFFF, after normal latency.
- Preload MTHI 0x1234 and MTLO 0x5678 -> values visible the next cycle. Start DIVU, assert flush_i at cycle E0+10 -> busy_o=0 next cycle, no done_o, HI/LO still 0x1234/0x5678.
- Start MULT, assert rst at cycle E0+5 -> next cycle busy_o=0, HI=LO=0. A start_i during busy is ignored (result matches the first op only).
